mips_cpu_mem_arbiter: RTL and testbench

- Shares one Avalon-style memory port between the CPU instruction-fetch requester and the data (load/store) requester.
- Arbitrates between the two, then registers and issues the winning transaction.
- Holds the transaction until the memory releases waitrequest, then returns a one-cycle ready pulse with registered read data to the winner.
- Sits between the CPU core and the unified memory, so instruction and data accesses use a single bus.

---
 rtl/mips_cpu_mem_arbiter_if.sv | 42 ++++
 rtl/mips_cpu_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mips_cpu_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_mem_arbiter_if.sv
// Bus bundle for mips_cpu_mem_arbiter: fetch requester, data requester
// and the shared Avalon-style memory port, seen from the arbiter (master).
interface mips_cpu_mem_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ready;
   logic [31:0]       i_rdata;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [31:0]       d_wdata;
   logic [3:0]        d_byteenable;
   logic              d_ready;
   logic [31:0]       d_rdata;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_read;
   logic              mem_write;
   logic [31:0]       mem_writedata;
   logic [3:0]        mem_byteenable;
   logic              mem_waitrequest;
   logic [31:0]       mem_readdata;

   modport master (
      input  i_req, i_addr,
      input  d_read, d_write, d_addr, d_wdata, d_byteenable,
      input  mem_waitrequest, mem_readdata,
      output i_ready, i_rdata, d_ready, d_rdata,
      output mem_address, mem_read, mem_write,
      output mem_writedata, mem_byteenable
   );

   modport slave (
      output i_req, i_addr,
      output d_read, d_write, d_addr, d_wdata, d_byteenable,
      output mem_waitrequest, mem_readdata,
      input  i_ready, i_rdata, d_ready, d_rdata,
      input  mem_address, mem_read, mem_write,
      input  mem_writedata, mem_byteenable
   );
endinterface

// File: rtl/mips_cpu_mem_arbiter.sv
// Fetch/data arbiter onto one memory port (IDLE -> ISSUE -> RESP).
// Define MIPS_CPU_MEM_ARB_STATS_EN to add grant/stall counters.
module mips_cpu_mem_arbiter #(
   parameter int DATA_PRIORITY = 0,
   parameter int ADDR_W        = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
`ifdef MIPS_CPU_MEM_ARB_STATS_EN
   output logic [15:0]            stat_i_grants,
   output logic [15:0]            stat_d_grants,
   output logic [15:0]            stat_stall_cycles,
`endif
   mips_cpu_mem_arbiter_if.master bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;
   localparam logic       GNT_I = 1'b0;
   localparam logic       GNT_D = 1'b1;

   logic [1:0]        state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       i_rdata_q, i_rdata_d;
   logic [31:0]       d_rdata_q, d_rdata_d;
   logic              i_ready_q, i_ready_d;
   logic              d_ready_q, d_ready_d;
   logic              d_req;
   logic              pick_d;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      addr_d       = addr_q;
      rd_d         = rd_q;
      wr_d         = wr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      i_ready_d    = 1'b0;
      d_ready_d    = 1'b0;
      d_req        = bus.d_read | bus.d_write;
      pick_d       = 1'b0;
      unique case (state_q)
         IDLE: begin
            // data wins outright, or on a conflict by priority/round-robin
            pick_d = d_req & (~bus.i_req | (DATA_PRIORITY != 0) |
                              (last_grant_q == GNT_I));
            if (pick_d) begin
               addr_d       = bus.d_addr;
               rd_d         = bus.d_read & ~bus.d_write;
               wr_d         = bus.d_write;
               wdata_d      = bus.d_wdata;
               be_d         = bus.d_byteenable;
               owner_d      = GNT_D;
               last_grant_d = GNT_D;
               state_d      = ISSUE;
            end else if (bus.i_req) begin
               addr_d       = bus.i_addr;
               rd_d         = 1'b1;
               wr_d         = 1'b0;
               wdata_d      = '0;
               be_d         = 4'hF;
               owner_d      = GNT_I;
               last_grant_d = GNT_I;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            if (!bus.mem_waitrequest) begin
               if (owner_q == GNT_D) begin
                  if (rd_q) d_rdata_d = bus.mem_readdata;
                  d_ready_d = 1'b1;
               end else begin
                  i_rdata_d = bus.mem_readdata;
                  i_ready_d = 1'b1;
               end
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         last_grant_q <= GNT_I;
         owner_q      <= GNT_I;
         addr_q       <= '0;
         rd_q         <= 1'b0;
         wr_q         <= 1'b0;
         wdata_q      <= '0;
         be_q         <= '0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         i_ready_q    <= 1'b0;
         d_ready_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         addr_q       <= addr_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         i_ready_q    <= i_ready_d;
         d_ready_q    <= d_ready_d;
      end
   end

   assign bus.mem_address    = addr_q;
   assign bus.mem_read       = rd_q;
   assign bus.mem_write      = wr_q;
   assign bus.mem_writedata  = wdata_q;
   assign bus.mem_byteenable = be_q;
   assign bus.i_ready        = i_ready_q;
   assign bus.i_rdata        = i_rdata_q;
   assign bus.d_ready        = d_ready_q;
   assign bus.d_rdata        = d_rdata_q;

`ifdef MIPS_CPU_MEM_ARB_STATS_EN
   logic        grant_i, grant_d, stall;
   logic [15:0] si_q, si_d, sd_q, sd_d, ss_q, ss_d;

   assign grant_i = (state_q == IDLE) && (state_d == ISSUE) && (owner_d == GNT_I);
   assign grant_d = (state_q == IDLE) && (state_d == ISSUE) && (owner_d == GNT_D);
   assign stall   = (state_q == ISSUE) && bus.mem_waitrequest;

   always_comb begin
      si_d = si_q + 16'(grant_i);
      sd_d = sd_q + 16'(grant_d);
      ss_d = ss_q + 16'(stall);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         si_q <= '0;
         sd_q <= '0;
         ss_q <= '0;
      end else begin
         si_q <= si_d;
         sd_q <= sd_d;
         ss_q <= ss_d;
      end
   end

   assign stat_i_grants     = si_q;
   assign stat_d_grants     = sd_q;
   assign stat_stall_cycles = ss_q;
`endif
endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Scoreboard bench: two arbiters (DATA_PRIORITY 0 and 1) share the
// request stimulus; a negedge monitor pops expected mem/ready events.
`timescale 1ns/1ps
module tb_mips_cpu_mem_arbiter;
   typedef struct {
      logic        d;
      logic [31:0] rdata;
      int          cyc;
   } rsp_t;
   typedef struct {
      logic [31:0] addr;
      logic        rd;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          cyc;
   } mem_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   int          cyc = 0;
   int          n_pass = 0;
   int          n_total = 0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        d_read = 1'b0;
   logic        d_write = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [3:0]  d_be = '0;
   int          wait_cfg = 0;
   int          wcnt [2] = '{0, 0};
   logic        pstr [2] = '{1'b0, 1'b0};
   logic        prdy [2] = '{1'b0, 1'b0};
   logic [69:0] held [2];
   rsp_t        rq0[$], rq1[$];
   mem_t        mq0[$], mq1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mips_cpu_mem_arbiter_if #(.ADDR_W(32)) bus0();
   mips_cpu_mem_arbiter_if #(.ADDR_W(32)) bus1();

   assign bus0.i_req        = i_req;
   assign bus0.i_addr       = i_addr;
   assign bus0.d_read       = d_read;
   assign bus0.d_write      = d_write;
   assign bus0.d_addr       = d_addr;
   assign bus0.d_wdata      = d_wdata;
   assign bus0.d_byteenable = d_be;
   assign bus1.i_req        = i_req;
   assign bus1.i_addr       = i_addr;
   assign bus1.d_read       = d_read;
   assign bus1.d_write      = d_write;
   assign bus1.d_addr       = d_addr;
   assign bus1.d_wdata      = d_wdata;
   assign bus1.d_byteenable = d_be;

`ifdef MIPS_CPU_MEM_ARB_STATS_EN
   logic [15:0] st0_i, st0_d, st0_s, st1_i, st1_d, st1_s;
`endif

   mips_cpu_mem_arbiter #(.DATA_PRIORITY(0), .ADDR_W(32)) dut0 (
      .clk               (clk),
      .reset_n           (reset_n),
`ifdef MIPS_CPU_MEM_ARB_STATS_EN
      .stat_i_grants     (st0_i),
      .stat_d_grants     (st0_d),
      .stat_stall_cycles (st0_s),
`endif
      .bus               (bus0)
   );

   mips_cpu_mem_arbiter #(.DATA_PRIORITY(1), .ADDR_W(32)) dut1 (
      .clk               (clk),
      .reset_n           (reset_n),
`ifdef MIPS_CPU_MEM_ARB_STATS_EN
      .stat_i_grants     (st1_i),
      .stat_d_grants     (st1_d),
      .stat_stall_cycles (st1_s),
`endif
      .bus               (bus1)
   );

   task automatic chk(string nm, int k, logic [127:0] act, logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dp%0d: got %0h want %0h", nm, k, act, exp);
   endtask

   function automatic logic [31:0] memword(logic [31:0] a);
      if (a == 32'hBFC00000) return 32'h24020005;
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic next_wait(int k, logic s);
      if (!s) begin
         wcnt[k] = 0;
         return 1'b0;
      end
      if (wcnt[k] < wait_cfg) begin
         wcnt[k]++;
         return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic exp_mem(int k, logic [31:0] a, logic rd, logic wr,
                          logic [31:0] wd, logic [3:0] be, int c);
      mem_t m;
      m.addr = a; m.rd = rd; m.wr = wr; m.wdata = wd; m.be = be; m.cyc = c;
      if (k == 0) mq0.push_back(m);
      else mq1.push_back(m);
   endtask

   task automatic exp_rsp(int k, logic d, logic [31:0] rd, int c);
      rsp_t r;
      r.d = d; r.rdata = rd; r.cyc = c;
      if (k == 0) rq0.push_back(r);
      else rq1.push_back(r);
   endtask

   task automatic mon(int k, logic ir, logic dr, logic [31:0] ird,
                      logic [31:0] drd, logic [31:0] ad, logic rd,
                      logic wr, logic [31:0] wd, logic [3:0] be);
      rsp_t r;
      mem_t m;
      logic have;
      logic s;
      if (!reset_n) begin
         pstr[k] = 1'b0;
         prdy[k] = 1'b0;
         return;
      end
      if (ir || dr) begin
         chk("ready_onehot", k, ir & dr, 0);
         chk("ready_width", k, prdy[k], 0);
         chk("resp_strobes", k, {rd, wr}, 0);
         have = 1'b0;
         if (k == 0 && rq0.size() > 0) begin r = rq0.pop_front(); have = 1'b1; end
         if (k == 1 && rq1.size() > 0) begin r = rq1.pop_front(); have = 1'b1; end
         if (!have) begin
            n_total++;
            $display("FAIL unexpected_ready dp%0d: got i=%0b d=%0b want none", k, ir, dr);
         end else begin
            chk("ready_who", k, dr, r.d);
            chk("rdata", k, dr ? drd : ird, r.rdata);
            chk("ready_cyc", k, cyc, r.cyc);
         end
      end
      prdy[k] = ir | dr;
      s = rd | wr;
      if (s && !pstr[k]) begin
         have = 1'b0;
         if (k == 0 && mq0.size() > 0) begin m = mq0.pop_front(); have = 1'b1; end
         if (k == 1 && mq1.size() > 0) begin m = mq1.pop_front(); have = 1'b1; end
         if (!have) begin
            n_total++;
            $display("FAIL unexpected_issue dp%0d: got addr %0h want none", k, ad);
         end else begin
            chk("mem_addr", k, ad, m.addr);
            chk("mem_strb", k, {rd, wr}, {m.rd, m.wr});
            chk("mem_wdata", k, wd, m.wdata);
            chk("mem_be", k, be, m.be);
            chk("issue_cyc", k, cyc, m.cyc);
         end
         held[k] = {ad, rd, wr, wd, be};
      end else if (s) begin
         chk("mem_stable", k, {ad, rd, wr, wd, be}, held[k]);
      end
      pstr[k] = s;
   endtask

   initial begin
      bus0.mem_waitrequest = 1'b0;
      bus0.mem_readdata    = '0;
      bus1.mem_waitrequest = 1'b0;
      bus1.mem_readdata    = '0;
      forever begin
         @(negedge clk);
         mon(0, bus0.i_ready, bus0.d_ready, bus0.i_rdata, bus0.d_rdata,
             bus0.mem_address, bus0.mem_read, bus0.mem_write,
             bus0.mem_writedata, bus0.mem_byteenable);
         mon(1, bus1.i_ready, bus1.d_ready, bus1.i_rdata, bus1.d_rdata,
             bus1.mem_address, bus1.mem_read, bus1.mem_write,
             bus1.mem_writedata, bus1.mem_byteenable);
         bus0.mem_waitrequest = next_wait(0, bus0.mem_read | bus0.mem_write);
         bus0.mem_readdata    = memword(bus0.mem_address);
         bus1.mem_waitrequest = next_wait(1, bus1.mem_read | bus1.mem_write);
         bus1.mem_readdata    = memword(bus1.mem_address);
      end
   end

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int b;
      step(3);
      chk("rst_i_ready", 0, bus0.i_ready, 0);
      chk("rst_d_ready", 0, bus0.d_ready, 0);
      chk("rst_i_rdata", 0, bus0.i_rdata, 0);
      chk("rst_d_rdata", 0, bus0.d_rdata, 0);
      chk("rst_mem_addr", 0, bus0.mem_address, 0);
      chk("rst_mem_read", 0, bus0.mem_read, 0);
      chk("rst_mem_write", 0, bus0.mem_write, 0);
      chk("rst_mem_wdata", 0, bus0.mem_writedata, 0);
      chk("rst_mem_be", 0, bus0.mem_byteenable, 0);
      chk("rst_mem_read", 1, bus1.mem_read, 0);
      chk("rst_mem_write", 1, bus1.mem_write, 0);
      reset_n = 1'b1;
      step(1);

      // single fetch, zero wait states
      b = cyc;
      i_req = 1'b1; i_addr = 32'hBFC00000;
      for (int k = 0; k < 2; k++) begin
         exp_mem(k, 32'hBFC00000, 1'b1, 1'b0, 32'h0, 4'hF, b + 1);
         exp_rsp(k, 1'b0, 32'h24020005, b + 2);
      end
      step(3);
      i_req = 1'b0;

      // store held off by four wait cycles
      b = cyc;
      wait_cfg = 4;
      d_write = 1'b1; d_addr = 32'h00001004; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
      for (int k = 0; k < 2; k++) begin
         exp_mem(k, 32'h00001004, 1'b0, 1'b1, 32'hDEADBEEF, 4'h3, b + 1);
         exp_rsp(k, 1'b1, 32'h0, b + 6);
      end
      step(7);
      d_write = 1'b0;
      wait_cfg = 0;

      // data read
      b = cyc;
      d_read = 1'b1; d_addr = 32'h10008000; d_wdata = 32'h11112222; d_be = 4'hF;
      for (int k = 0; k < 2; k++) begin
         exp_mem(k, 32'h10008000, 1'b1, 1'b0, 32'h11112222, 4'hF, b + 1);
         exp_rsp(k, 1'b1, 32'h80007FFF, b + 2);
      end
      step(3);

      // read+write together acts as a write; d_rdata keeps the last read
      b = cyc;
      d_write = 1'b1; d_addr = 32'h00002000; d_wdata = 32'hCAFEF00D;
      for (int k = 0; k < 2; k++) begin
         exp_mem(k, 32'h00002000, 1'b0, 1'b1, 32'hCAFEF00D, 4'hF, b + 1);
         exp_rsp(k, 1'b1, 32'h80007FFF, b + 2);
      end
      step(3);
      d_read = 1'b0; d_write = 1'b0;

      // reset while the memory stalls a fetch
      b = cyc;
      wait_cfg = 1000;
      i_req = 1'b1; i_addr = 32'h00400000;
      for (int k = 0; k < 2; k++)
         exp_mem(k, 32'h00400000, 1'b1, 1'b0, 32'h0, 4'hF, b + 1);
      step(3);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_mem_read", 0, bus0.mem_read, 0);
      chk("arst_mem_read", 1, bus1.mem_read, 0);
      chk("arst_mem_addr", 0, bus0.mem_address, 0);
      chk("arst_i_rdata", 0, bus0.i_rdata, 0);
      chk("arst_d_rdata", 0, bus0.d_rdata, 0);
      i_req = 1'b0;
      wait_cfg = 0;
      step(2);
      reset_n = 1'b1;

      // both requesters held: dp0 alternates D,I,D,I; dp1 keeps granting D
      b = cyc;
      i_req = 1'b1; i_addr = 32'h00400000;
      d_read = 1'b1; d_addr = 32'h10008000; d_wdata = 32'h0; d_be = 4'hF;
      for (int j = 0; j < 4; j++) begin
         if (j % 2 == 0) begin
            exp_mem(0, 32'h10008000, 1'b1, 1'b0, 32'h0, 4'hF, b + 3*j + 1);
            exp_rsp(0, 1'b1, 32'h80007FFF, b + 3*j + 2);
         end else begin
            exp_mem(0, 32'h00400000, 1'b1, 1'b0, 32'h0, 4'hF, b + 3*j + 1);
            exp_rsp(0, 1'b0, 32'h0000FFFF, b + 3*j + 2);
         end
         exp_mem(1, 32'h10008000, 1'b1, 1'b0, 32'h0, 4'hF, b + 3*j + 1);
         exp_rsp(1, 1'b1, 32'h80007FFF, b + 3*j + 2);
      end
      for (int k = 0; k < 2; k++) begin
         exp_mem(k, 32'h00400000, 1'b1, 1'b0, 32'h0, 4'hF, b + 13);
         exp_rsp(k, 1'b0, 32'h0000FFFF, b + 14);
      end
      step(12);
      d_read = 1'b0;
      step(3);
      i_req = 1'b0;
      step(4);

      chk("rsp_drain", 0, rq0.size(), 0);
      chk("rsp_drain", 1, rq1.size(), 0);
      chk("mem_drain", 0, mq0.size(), 0);
      chk("mem_drain", 1, mq1.size(), 0);
`ifdef MIPS_CPU_MEM_ARB_STATS_EN
      chk("stat_i", 0, st0_i, 3);
      chk("stat_d", 0, st0_d, 2);
      chk("stat_s", 0, st0_s, 0);
      chk("stat_i", 1, st1_i, 1);
      chk("stat_d", 1, st1_d, 4);
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
